// File: rtl/adam_aes_stream_adapter.sv
// rtl/adam_aes_stream_adapter.sv - 32-bit stream to 128-bit AES core block adapter
module adam_aes_stream_adapter #(
  parameter int IN_BLOCKS = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             core_start,
  input  logic             core_ready,
  output logic [127:0]     core_block,
  input  logic             core_result_valid,
  input  logic [127:0]     core_result,
  output logic             busy,
  output logic [CNT_W-1:0] blocks_done
);

  localparam int PW = $clog2(IN_BLOCKS);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, DRAIN} state_t;

  state_t         state;
  state_t         state_next;

  logic [1:0]     word_cnt;
  logic [95:0]    part;
  logic [127:0]   fifo_mem [IN_BLOCKS];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  fifo_count;
  logic [127:0]   out_buf;
  logic [1:0]     out_cnt;

  logic           in_fire;
  logic           push;
  logic           pop;
  logic           capture;
  logic           out_fire;
  logic           out_last;
  logic           out_free;

  // Ready depends on the registered FIFO count only; no same-cycle bypass on a pop.
  assign in_ready   = (fifo_count != CW'(IN_BLOCKS));
  assign in_fire    = in_valid & in_ready;
  assign push       = in_fire & (word_cnt == 2'd3) & ~clear;
  assign pop        = capture;
  assign out_fire   = out_valid & out_ready;
  assign out_last   = out_fire & (out_cnt == 2'd3);
  // The output buffer counts as free during the cycle of its last handshake.
  assign out_free   = ~out_valid | out_last;
  assign core_block = fifo_mem[rd_ptr];
  assign core_start = (state == START);
  assign out_data   = out_buf[127:96];

  // Word packer: the first three words are held until the fourth completes the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt <= 2'd0;
      part     <= '0;
    end else if (clear) begin
      word_cnt <= 2'd0;
    end else if (in_fire) begin
      case (word_cnt)
        2'd0:    part[95:64] <= in_data;
        2'd1:    part[63:32] <= in_data;
        2'd2:    part[31:0]  <= in_data;
        default: ;
      endcase
      word_cnt <= word_cnt + 2'd1;
    end
  end

  // Input block FIFO; the head entry feeds the core directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < IN_BLOCKS; i++) fifo_mem[i] <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {part, in_data};
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Core sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  // Core sequencer next state; IDLE looks ahead at this cycle's push so a start follows the 4th word directly.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!clear && ((fifo_count != '0) || push) && core_ready && out_free)
          state_next = START;
      end
      START: begin
        state_next = clear ? DRAIN : WAIT;
      end
      WAIT: begin
        if (core_result_valid) begin
          capture    = ~clear;
          state_next = IDLE;
        end else if (clear) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (core_result_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output unpacker: shift the captured result out one big-endian word per handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_buf   <= '0;
      out_cnt   <= 2'd0;
      out_valid <= 1'b0;
    end else if (clear) begin
      out_buf   <= '0;
      out_cnt   <= 2'd0;
      out_valid <= 1'b0;
    end else if (capture) begin
      out_buf   <= core_result;
      out_cnt   <= 2'd0;
      out_valid <= 1'b1;
    end else if (out_fire) begin
      out_buf <= {out_buf[95:0], 32'd0};
      out_cnt <= out_cnt + 2'd1;
      if (out_cnt == 2'd3) out_valid <= 1'b0;
    end
  end

  // Completed-block counter survives clear and wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blocks_done <= '0;
    else if (capture) blocks_done <= blocks_done + CNT_W'(1);
  end

endmodule
